uart_tx_port: RTL
=================

// Module: uart_tx_port
// PURPOSE
//  Memory-mapped UART transmitter; the bus responder for the CPU's MEM-stage load/store port (rd/wr/addr/wdata/rdata).
//  Stores write bytes into a small FIFO and serialises them as 8N1 frames on uart_tx.
//  Raises irq after each completed frame when interrupts are enabled.
//  Sits beside the data memory and the other peripherals, decoded on the 0x4000_00xx peripheral window.
// PARAMETERS
//  CLKS_PER_BIT  5208          clk cycles per UART bit (50 MHz / 9600); legal range >=2
//  FIFO_DEPTH    4             TX byte FIFO entries; power of two, >=2
//  ADDR_TXD      32'h40000018  write: push wdata[7:0]; read: returns 0
//  ADDR_CON      32'h40000020  control/status register
// PORTS
//  clk      in   1   core clock (same clk as pipeline registers)
//  reset    in   1   asynchronous, active-low
//  rd       in   1   bus read strobe (MEM stage)
//  wr       in   1   bus write strobe (MEM stage)
//  addr     in   32  byte address (ALU result of the MEM stage)
//  wdata    in   32  store data
//  rdata    out  32  read data, combinational
//  irq      out  1   interrupt request, level
//  uart_tx  out  1   serial line, idle high
// BEHAVIOUR
//  Reset (async, reset==0): FIFO empty, state IDLE, uart_tx=1, CON.ien=0, done=0, ovf=0, irq=0.
//   rdata=0 during reset. Reset mid-frame aborts the frame: uart_tx=1 at once; queued bytes discarded.
//  CON read value: {27'b0, ovf[4], busy[3], full[2], done[1], ien[0]}.
//   busy = (state!=IDLE) | FIFO not empty; full = FIFO count==FIFO_DEPTH.
//  rdata = rd & addr==ADDR_CON ? CON : 32'h0 (TXD reads and unmapped addresses return 0).
//  Writes (sampled posedge clk when wr=1):
//   ADDR_TXD: if !full push wdata[7:0]; if full byte dropped and ovf<=1.
//   ADDR_CON: ien<=wdata[0]; wdata[4]==1 clears ovf; done not writable.
//   Other addresses: ignored. rd&wr together: both performed.
//  done: set on the final STOP-bit cycle; cleared by a CON read (rd & addr==ADDR_CON, at posedge).
//   Set and clear in same cycle -> set wins (no lost completion).
//  irq = ien & done (registered flags, no extra delay).
//  TX FSM (bit counter 3b, baud counter sized for CLKS_PER_BIT-1):
//   IDLE : uart_tx=1; if FIFO not empty -> pop head into shift reg, baud_cnt<=0, -> START.
//   START: uart_tx=0 for CLKS_PER_BIT cycles -> DATA, bit_idx<=0.
//   DATA : uart_tx=shift[0], LSB first; every CLKS_PER_BIT cycles shift right, bit_idx++;
//          after bit 7 -> STOP.
//   STOP : uart_tx=1 for CLKS_PER_BIT cycles; last cycle sets done; -> IDLE.
//  uart_tx is a registered output (no glitches).
//  Latency: TXD write at edge N -> pop at edge N+1 (if IDLE) -> start bit drives from edge N+2.
//   Frame = 10*CLKS_PER_BIT cycles; back-to-back bytes: exactly one IDLE cycle between frames.
//  Simultaneous push and pop on a full FIFO: pop frees a slot the same cycle -> push accepted, no ovf.
//   Push into empty FIFO while IDLE: not visible to FSM until next edge.
//  FIFO pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
// STRUCTURE
//  Shared package/header: ADDR_TXD, ADDR_CON, CON bit indices (CON_IEN=0, CON_DONE=1,
//   CON_FULL=2, CON_BUSY=3, CON_OVF=4), FSM state encoding (IDLE/START/DATA/STOP, 2 bits).
//  Sub-module uart_tx_fifo: sync FIFO (push, pop, din[7:0], dout[7:0], full, empty, count),
//   first-word-fall-through, simultaneous push/pop when full allowed.
//  Top: address decode, CON register, irq, TX FSM + baud/bit counters.
// TESTING (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4)
//  1 wr TXD 0x55 -> uart_tx low 4 cycles from N+2, then 1,0,1,0,1,0,1,0 (4 cyc each), high 4; done=1.
//  2 ien=1 via wr CON 0x1, send 0xA3 -> irq rises at STOP end; rd CON returns 0x0B/0x03 then irq=0.
//  3 6 writes to TXD back-to-back while IDLE -> 1 popped + 4 queued, 6th dropped, CON[4]=1;
//    wr CON 0x10 -> ovf=0; 5 frames emitted in order.
//  4 CON read coinciding with STOP last cycle -> done stays 1, irq stays asserted.
//  5 reset low mid-DATA of 0xFF -> uart_tx=1 immediately, CON reads 0 after release, no further frames.
//  6 rd to 0x40000018 and 0x00000010 -> rdata=0; wr to unmapped -> no FIFO/CON change.

Source files
------------

// File: rtl/uart_tx_port_pkg.sv
// Shared definitions for the UART transmitter port: bus addresses,
// control/status bit positions and the TX state encoding.
package uart_tx_port_pkg;

    localparam logic [31:0] ADDR_TXD_DEF = 32'h4000_0018;
    localparam logic [31:0] ADDR_CON_DEF = 32'h4000_0020;

    localparam int CON_IEN  = 0;
    localparam int CON_DONE = 1;
    localparam int CON_FULL = 2;
    localparam int CON_BUSY = 3;
    localparam int CON_OVF  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_port_if.sv
// MEM-stage load/store bus as seen by a memory-mapped peripheral.
interface uart_tx_port_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output rd, wr, addr, wdata, input rdata);
    modport slave  (input rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO, first-word-fall-through; a pop on a full FIFO makes room for
// a push in the same cycle.
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [7:0]                 din,
    output logic [7:0]                 dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_push, do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rp];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: TXD writes queue bytes, CON holds
// interrupt enable, sticky done/overflow flags and live status.
module uart_tx_port
    import uart_tx_port_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 5208,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] ADDR_TXD     = ADDR_TXD_DEF,
    parameter logic [31:0] ADDR_CON     = ADDR_CON_DEF
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_port_if.slave bus,
    output logic          irq,
    output logic          uart_tx
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    logic txd_wr, con_wr, con_rd;
    logic fifo_pop, fifo_full, fifo_empty, drop, busy;
    logic [7:0] fifo_dout;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic ien, done, ovf;
    logic [31:0] con_val;

    tx_state_t   state, state_nxt;
    logic [BW-1:0] baud_cnt, baud_nxt;
    logic [2:0]  bit_idx, bit_nxt;
    logic [7:0]  shift, shift_nxt;
    logic        tx_nxt, frame_done, baud_end;

    assign txd_wr = bus.wr && (bus.addr == ADDR_TXD);
    assign con_wr = bus.wr && (bus.addr == ADDR_CON);
    assign con_rd = bus.rd && (bus.addr == ADDR_CON);
    assign drop   = txd_wr && fifo_full && !fifo_pop;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (txd_wr),
        .pop   (fifo_pop),
        .din   (bus.wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign baud_end = (baud_cnt == BAUD_LAST);

    // tx_nxt is decoded from the current state, so the line trails the FSM by one cycle
    always_comb begin
        state_nxt  = state;
        baud_nxt   = baud_end ? '0 : baud_cnt + 1'b1;
        bit_nxt    = bit_idx;
        shift_nxt  = shift;
        fifo_pop   = 1'b0;
        frame_done = 1'b0;
        tx_nxt     = 1'b1;
        case (state)
            IDLE: begin
                baud_nxt = '0;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_nxt = fifo_dout;
                    state_nxt = START;
                end
            end
            START: begin
                tx_nxt = 1'b0;
                if (baud_end) begin
                    state_nxt = DATA;
                    bit_nxt   = '0;
                end
            end
            DATA: begin
                tx_nxt = shift[0];
                if (baud_end) begin
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        shift_nxt = shift >> 1;
                        bit_nxt   = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                tx_nxt = 1'b1;
                if (baud_end) begin
                    state_nxt  = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            uart_tx  <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            shift    <= shift_nxt;
            uart_tx  <= tx_nxt;
        end
    end

    // Setting a flag beats clearing it in the same cycle so no event is lost
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ien  <= 1'b0;
            done <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            if (con_wr) ien <= bus.wdata[CON_IEN];
            if (frame_done)  done <= 1'b1;
            else if (con_rd) done <= 1'b0;
            if (drop)                              ovf <= 1'b1;
            else if (con_wr && bus.wdata[CON_OVF]) ovf <= 1'b0;
        end
    end

    assign busy = (state != IDLE) || (fifo_count != '0);

    always_comb begin
        con_val           = '0;
        con_val[CON_IEN]  = ien;
        con_val[CON_DONE] = done;
        con_val[CON_FULL] = fifo_full;
        con_val[CON_BUSY] = busy;
        con_val[CON_OVF]  = ovf;
    end

    assign bus.rdata = (reset && con_rd) ? con_val : 32'h0;
    assign irq       = ien && done;
endmodule
